// File: rtl/icache_ctrl_if.sv
// rtl/icache_ctrl_if.sv - CPU fetch and instruction-memory refill bus for icache_ctrl
interface icache_ctrl_if;
    logic        cpu_req;
    logic [7:0]  cpu_addr;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;

    modport master (
        output cpu_req, cpu_addr, mem_rdata,
        input  cpu_ready, cpu_rdata, mem_rd, mem_addr
    );

    modport slave (
        input  cpu_req, cpu_addr, mem_rdata,
        output cpu_ready, cpu_rdata, mem_rd, mem_addr
    );
endinterface

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped 8x4x16-bit instruction cache controller with hit/miss counters
module icache_ctrl (
    input  logic              mem_clk,
    input  logic              rst_n,
    icache_ctrl_if.slave      bus,
    input  logic              flush,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [7:0]  valid_q;
    logic [2:0]  tag_q  [0:7];
    logic [15:0] data_q [0:31];

    logic [2:0]  idx;
    logic [2:0]  tag;
    logic [1:0]  off;
    logic        hit;
    logic        hit_inc;
    logic        miss_inc;
    logic        fill_done;

    assign tag = bus.cpu_addr[7:5];
    assign idx = bus.cpu_addr[4:2];
    assign off = bus.cpu_addr[1:0];
    assign hit = bus.cpu_req & valid_q[idx] & (tag_q[idx] == tag);

    assign hit_inc   = (state_q == IDLE) & hit & ~flush;
    assign miss_inc  = (state_q == IDLE) & bus.cpu_req & ~hit & ~flush;
    // A flush on the final refill beat must leave the line invalid.
    assign fill_done = (state_q == REFILL) & (cnt_q == 2'd3) & ~flush;

    always_comb begin
        state_d       = state_q;
        bus.cpu_ready = 1'b0;
        bus.cpu_rdata = data_q[{idx, off}];
        bus.mem_rd    = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req && !flush) begin
                    if (hit) bus.cpu_ready = 1'b1;
                    else     state_d = REFILL;
                end
            end
            REFILL: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = {bus.cpu_addr[7:2], cnt_q};
                if (flush)              state_d = IDLE;
                else if (cnt_q == 2'd3) state_d = RESP;
            end
            RESP: begin
                bus.cpu_ready = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            valid_q  <= 8'd0;
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == REFILL) cnt_q <= cnt_q + 2'd1;
            else                   cnt_q <= 2'd0;
            if (flush)          valid_q      <= 8'd0;
            else if (fill_done) valid_q[idx] <= 1'b1;
            if (hit_inc && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
            if (miss_inc && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end

    // Storage arrays carry no reset; validity alone decides whether contents are used.
    always_ff @(posedge mem_clk) begin
        if (state_q == REFILL && !flush) data_q[{idx, cnt_q}] <= bus.mem_rdata;
        if (fill_done)                   tag_q[idx]           <= tag;
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed self-checking bench for icache_ctrl
module tb_icache_ctrl;
    logic        mem_clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    int          n_tests;
    int          n_fail;

    icache_ctrl_if bus ();

    icache_ctrl dut (
        .mem_clk  (mem_clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .flush    (flush),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    always_comb begin
        case (bus.mem_addr)
            8'h00:   bus.mem_rdata = 16'h1300;
            8'h01:   bus.mem_rdata = 16'h5B02;
            8'h02:   bus.mem_rdata = 16'h4100;
            8'h03:   bus.mem_rdata = 16'h4230;
            default: bus.mem_rdata = {bus.mem_addr, bus.mem_addr};
        endcase
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive inputs just after a falling edge and sample 1 ns later.
    task automatic cycle(input logic req, input logic [7:0] a, input logic f);
        @(negedge mem_clk);
        bus.cpu_req  = req;
        bus.cpu_addr = a;
        flush        = f;
        #1;
    endtask

    // Called in the miss cycle (cycle 0); returns while sampling the RESP cycle (cycle 5).
    task automatic serve_miss(input logic [7:0] a, input logic [15:0] d);
        check("miss_ready0", 16'(bus.cpu_ready), 16'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, a, 1'b0);
            check("refill_rd", 16'(bus.mem_rd), 16'd1);
            check("refill_addr", 16'(bus.mem_addr), 16'({a[7:2], 2'(i)}));
        end
        cycle(1'b1, a, 1'b0);
        check("resp_ready", 16'(bus.cpu_ready), 16'd1);
        check("resp_rdata", bus.cpu_rdata, d);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 8'h00;
        #12;
        check("rst_ready", 16'(bus.cpu_ready), 16'd0);
        check("rst_mem_rd", 16'(bus.mem_rd), 16'd0);
        check("rst_hit", hit_cnt, 16'd0);
        check("rst_miss", miss_cnt, 16'd0);
        @(negedge mem_clk);
        rst_n = 1'b1;

        // cold miss
        cycle(1'b1, 8'h02, 1'b0);
        check("cold_mem_rd0", 16'(bus.mem_rd), 16'd0);
        check("cold_mem_addr0", 16'(bus.mem_addr), 16'h0002);
        serve_miss(8'h02, 16'h4100);
        check("cold_miss", miss_cnt, 16'd1);
        check("cold_hit", hit_cnt, 16'd0);

        // hits after fill
        cycle(1'b1, 8'h03, 1'b0);
        check("hit03_ready", 16'(bus.cpu_ready), 16'd1);
        check("hit03_rdata", bus.cpu_rdata, 16'h4230);
        cycle(1'b1, 8'h00, 1'b0);
        check("hit00_ready", 16'(bus.cpu_ready), 16'd1);
        check("hit00_rdata", bus.cpu_rdata, 16'h1300);
        cycle(1'b0, 8'h00, 1'b0);
        check("idle_ready", 16'(bus.cpu_ready), 16'd0);
        check("hit_cnt2", hit_cnt, 16'd2);

        // conflict eviction, then the original line misses again
        cycle(1'b1, 8'h20, 1'b0);
        serve_miss(8'h20, 16'h2020);
        check("evict_miss", miss_cnt, 16'd2);
        cycle(1'b1, 8'h00, 1'b0);
        serve_miss(8'h00, 16'h1300);
        check("refetch_miss", miss_cnt, 16'd3);

        // flush in the second refill cycle aborts; retry misses again
        cycle(1'b1, 8'h24, 1'b0);
        cycle(1'b1, 8'h24, 1'b0);
        check("fl_addr1", 16'(bus.mem_addr), 16'h0024);
        cycle(1'b1, 8'h24, 1'b1);
        check("fl_rd2", 16'(bus.mem_rd), 16'd1);
        check("fl_addr2", 16'(bus.mem_addr), 16'h0025);
        cycle(1'b1, 8'h24, 1'b0);
        check("fl_idle_rd", 16'(bus.mem_rd), 16'd0);
        check("fl_idle_addr", 16'(bus.mem_addr), 16'h0024);
        check("fl_miss_before", miss_cnt, 16'd4);
        serve_miss(8'h24, 16'h2424);
        check("fl_miss_after", miss_cnt, 16'd5);

        // flush on an IDLE hit: no ready, no counting, line gone
        cycle(1'b1, 8'h24, 1'b1);
        check("flidle_ready", 16'(bus.cpu_ready), 16'd0);
        cycle(1'b1, 8'h24, 1'b0);
        check("flidle_hit", hit_cnt, 16'd2);
        check("flidle_miss", miss_cnt, 16'd5);
        serve_miss(8'h24, 16'h2424);
        check("flidle_miss2", miss_cnt, 16'd6);

        // reset in the middle of a refill
        cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h08, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rr_mem_rd", 16'(bus.mem_rd), 16'd0);
        check("rr_ready", 16'(bus.cpu_ready), 16'd0);
        check("rr_miss", miss_cnt, 16'd0);
        check("rr_hit", hit_cnt, 16'd0);
        @(negedge mem_clk);
        rst_n = 1'b1;
        #1;
        serve_miss(8'h08, 16'h0808);
        check("rr_miss_after", miss_cnt, 16'd1);

        // saturate hit_cnt with back-to-back hits, then one more
        begin
            int n;
            n = 0;
            while (hit_cnt != 16'hFFFF && n < 70000) begin
                cycle(1'b1, 8'h08, 1'b0);
                n++;
            end
        end
        check("sat_reach", hit_cnt, 16'hFFFF);
        cycle(1'b1, 8'h09, 1'b0);
        check("sat_ready", 16'(bus.cpu_ready), 16'd1);
        check("sat_rdata", bus.cpu_rdata, 16'h0909);
        cycle(1'b0, 8'h09, 1'b0);
        check("sat_hold", hit_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be, clock and reset first:
- mem_clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  fetch request
- cpu_addr  in  8  instruction word address
- cpu_ready  out  1  cpu_rdata valid this cycle
- cpu_rdata  out  16  instruction word
- flush  in  1  invalidate all lines
- mem_rd  out  1  refill read in progress
- mem_addr  out  8  word address to instruction memory
- mem_rdata  in  16  word at mem_addr, combinational, same cycle
- hit_cnt  out  16  saturating hit counter
- miss_cnt  out  16  saturating miss counter
REQ-003 Parameters SHALL be none; geometry is fixed:
- direct-mapped, 8 lines x 4 words of 16 bits
- address split tag=cpu_addr[7:5], index=cpu_addr[4:2], offset=cpu_addr[1:0]

Function
REQ-004 Each line SHALL hold a valid bit, a 3-bit tag and 4 data words.
- hit = cpu_req & valid[index] & (tag_array[index]==tag)
REQ-005 The FSM SHALL have exactly the states IDLE, REFILL and RESP.
REQ-006 In IDLE with cpu_req=1, hit=1 and flush=0:
- cpu_ready=1 combinationally in the same cycle
- cpu_rdata = data[index][offset]
- state stays IDLE
REQ-007 In IDLE with cpu_req=1, hit=0 and flush=0:
- cpu_ready=0
- state goes to REFILL at the next edge
- word counter cnt is cleared to 0
- miss_cnt increments
REQ-008 In REFILL:
- mem_rd=1
- mem_addr = {cpu_addr[7:2], cnt}
- each edge writes mem_rdata into data[index][cnt] and increments cnt
- on the edge where cnt==3: write tag, set valid, go to RESP
REQ-009 In RESP:
- cpu_ready=1 and cpu_rdata = data[index][offset]
- state returns to IDLE at the next edge
- hit_cnt does not change
REQ-010 Miss latency: a request first presented in cycle 0 SHALL be served in RESP in cycle 5; refill occupies cycles 1-4.
REQ-011 The requester SHALL hold cpu_req and cpu_addr stable while cpu_ready=0; behaviour is undefined otherwise.
REQ-012 hit_cnt SHALL increment once per cycle meeting REQ-006; both counters saturate at 16'hFFFF.
REQ-013 flush=1 SHALL clear all valid bits at the next edge, with priority over everything else:
- in IDLE: cpu_ready=0 that cycle, no counter change
- in REFILL: refill aborts to IDLE and the line stays invalid
- in RESP: the response completes, then all lines are invalid
REQ-014 mem_rd SHALL be 0 outside REFILL; mem_addr SHALL equal cpu_addr outside REFILL.
REQ-015 cpu_ready SHALL be 0 whenever cpu_req=0 in IDLE, and cpu_rdata is don't-care.

Reset
REQ-016 While rst_n=0, the block SHALL hold:
- state=IDLE, cnt=0
- all valid bits 0
- hit_cnt=0, miss_cnt=0
- cpu_ready=0, mem_rd=0
REQ-017 The data and tag arrays SHALL NOT be reset.
REQ-018 Reset asserted mid-REFILL SHALL discard the partial refill and leave the line invalid after release.

Verification
The memory model returns 16'h1300, 16'h5B02, 16'h4100, 16'h4230 at addresses 0-3 and {addr,addr} elsewhere.
REQ-019 Cold miss:
- stimulus: after reset, cpu_req=1, cpu_addr=8'h02
- mem_rd=1 in cycles 1-4 with mem_addr 00,01,02,03
- cycle 5: cpu_ready=1, cpu_rdata=16'h4100; miss_cnt=1, hit_cnt=0
REQ-020 Hit after fill:
- stimulus: cpu_addr=8'h03, then 8'h00 on consecutive cycles
- response: same-cycle cpu_ready with 16'h4230 then 16'h1300; hit_cnt=2
REQ-021 Conflict eviction:
- stimulus: cpu_addr=8'h20 (same index, tag 1)
- response: refill mem_addr 20-23; cpu_rdata=16'h2020; a later 8'h00 misses again
REQ-022 Flush mid-refill:
- stimulus: flush=1 in the second REFILL cycle
- response: IDLE next cycle; the retried request misses again; miss_cnt increments
REQ-023 Reset mid-refill:
- stimulus: rst_n=0 during REFILL
- response: outputs at reset values immediately; after release the same address misses
REQ-024 Saturation:
- stimulus: force hit_cnt to FFFF, then issue a hit
- response: hit_cnt stays FFFF
